// File: rtl/health_calc_pkg.sv
// rtl/health_calc_pkg.sv - shared widths, FSM encoding and requester indices
package health_calc_pkg;

  localparam int NUM_W_DEF = 48;
  localparam int Q_W_DEF   = 16;

  localparam logic REQ_SPO2 = 1'b0;
  localparam logic REQ_HR   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_seq_core.sv
// rtl/div_seq_core.sv - restoring divider, one quotient bit per step, MSB first
module div_seq_core
  import health_calc_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] den,
  output logic [NUM_W-1:0] quo
);

  // q starts as the dividend and is shifted out MSB first while quotient bits shift in
  logic [NUM_W-1:0] q;
  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] d;
  logic [NUM_W:0]   rem_sh;
  logic             ge;

  assign rem_sh = {rem, q[NUM_W-1]};
  assign ge     = (rem_sh >= {1'b0, d});
  assign quo    = q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
      d   <= '0;
    end else if (start) begin
      q   <= num;
      rem <= '0;
      d   <= den;
    end else if (step) begin
      q   <= {q[NUM_W-2:0], ge};
      rem <= ge ? NUM_W'(rem_sh - {1'b0, d}) : rem_sh[NUM_W-1:0];
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one sequential divider between two requesters
module div_arbiter
  import health_calc_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int Q_W   = Q_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_req,
  input  logic [NUM_W-1:0] i_num0,
  input  logic [NUM_W-1:0] i_num1,
  input  logic [NUM_W-1:0] i_den0,
  input  logic [NUM_W-1:0] i_den1,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic [Q_W-1:0]   o_quo,
  output logic             o_dz,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  state_t           state, state_nx;
  logic             last, winner, win_nx, dz_r;
  logic [CNT_W-1:0] iter;
  logic [1:0]       gnt_nx, done_nx;
  logic             core_start, core_step;
  logic [NUM_W-1:0] sel_num, sel_den, core_quo;

  assign sel_num = (winner == REQ_HR) ? i_num1 : i_num0;
  assign sel_den = (winner == REQ_HR) ? i_den1 : i_den0;

  // On a tie the requester not served last wins
  always_comb begin
    win_nx = REQ_SPO2;
    if (i_req == 2'b11)         win_nx = ~last;
    else if (i_req[REQ_HR])     win_nx = REQ_HR;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (|i_req) state_nx = S_LOAD;
      S_LOAD: state_nx = (sel_den == '0) ? S_DONE : S_RUN;
      S_RUN:  if (iter == CNT_W'(NUM_W - 1)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_nx     = 2'b00;
    done_nx    = 2'b00;
    core_start = (state == S_LOAD);
    core_step  = (state == S_RUN);
    o_busy     = (state != S_IDLE);
    if (state == S_IDLE && |i_req) gnt_nx  = 2'b01 << win_nx;
    if (state == S_DONE)           done_nx = 2'b01 << winner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= REQ_HR;
      winner <= REQ_SPO2;
      dz_r   <= 1'b0;
      iter   <= '0;
      o_gnt  <= 2'b00;
      o_done <= 2'b00;
      o_quo  <= '0;
      o_dz   <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      o_gnt  <= gnt_nx;
      o_done <= done_nx;
      if (state == S_IDLE && |i_req) winner <= win_nx;
      if (state == S_LOAD) begin
        dz_r <= (sel_den == '0);
        iter <= '0;
      end
      if (state == S_RUN) iter <= iter + 1'b1;
      if (state == S_DONE) begin
        last <= winner;
        o_dz <= dz_r;
        if (dz_r) begin
          o_quo <= '0;
          o_ovf <= 1'b0;
        end else if (|core_quo[NUM_W-1:Q_W]) begin
          o_quo <= '1;
          o_ovf <= 1'b1;
        end else begin
          o_quo <= core_quo[Q_W-1:0];
          o_ovf <= 1'b0;
        end
      end
    end
  end

  div_seq_core #(.NUM_W(NUM_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .step  (core_step),
    .num   (sel_num),
    .den   (sel_den),
    .quo   (core_quo)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;

  localparam int NUM_W = 48;
  localparam int Q_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       i_req = 2'b00;
  logic [NUM_W-1:0] i_num0 = '0, i_num1 = '0, i_den0 = '0, i_den1 = '0;
  logic [1:0]       o_gnt, o_done;
  logic [Q_W-1:0]   o_quo;
  logic             o_dz, o_ovf, o_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  div_arbiter #(.NUM_W(NUM_W), .Q_W(Q_W)) dut (
    .clk(clk), .rst(rst), .i_req(i_req),
    .i_num0(i_num0), .i_num1(i_num1), .i_den0(i_den0), .i_den1(i_den1),
    .o_gnt(o_gnt), .o_done(o_done), .o_quo(o_quo),
    .o_dz(o_dz), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) chk("gnt_done_overlap", 64'((o_gnt != 2'b00) && (o_done != 2'b00)), 64'd0);

  task automatic do_reset();
    i_req = 2'b00;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] req, input logic [1:0] req_after,
                     input logic [1:0] exp_gnt, input logic [1:0] exp_done, input int exp_lat,
                     input logic [Q_W-1:0] exp_quo, input logic exp_dz, input logic exp_ovf,
                     input bit scramble);
    int n;
    int t0;
    i_req = req;
    n = 0;
    do begin @(negedge clk); n++; end while (o_gnt == 2'b00 && n < 10);
    chk({tag, "_gnt"}, 64'(o_gnt), 64'(exp_gnt));
    chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    t0 = cyc;
    i_req = req_after;
    if (scramble) begin
      @(negedge clk);
      i_num0 = 48'h123456789;
      i_den0 = 48'h3;
      i_num1 = 48'h0;
      i_den1 = 48'h0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (o_done == 2'b00 && n < 80);
    chk({tag, "_done"}, 64'(o_done), 64'(exp_done));
    chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
    chk({tag, "_quo"}, 64'(o_quo), 64'(exp_quo));
    chk({tag, "_dz"}, 64'(o_dz), 64'(exp_dz));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ovf));
  endtask

  initial begin
    int seen;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_quo", 64'(o_quo), 64'd0);
    chk("rst_dz", 64'(o_dz), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd1 - 64'd1);
    rst = 1'b0;

    // Basic 1000/8, operands changed after LOAD
    i_num0 = 48'd1000; i_den0 = 48'd8;
    run("basic", 2'b01, 2'b00, 2'b01, 2'b01, 50, 16'd125, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("hold_quo", 64'(o_quo), 64'd125);
    chk("hold_done", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    i_num0 = 48'd100; i_den0 = 48'd7;
    i_num1 = 48'd999; i_den1 = 48'd3;
    run("tie0", 2'b11, 2'b10, 2'b01, 2'b01, 50, 16'd14, 1'b0, 1'b0, 1'b0);
    run("tie1", 2'b10, 2'b00, 2'b10, 2'b10, 50, 16'd333, 1'b0, 1'b0, 1'b0);

    // Continuous requests alternate
    run("rr_a", 2'b11, 2'b11, 2'b01, 2'b01, 50, 16'd14, 1'b0, 1'b0, 1'b0);
    run("rr_b", 2'b11, 2'b11, 2'b10, 2'b10, 50, 16'd333, 1'b0, 1'b0, 1'b0);
    run("rr_c", 2'b11, 2'b11, 2'b01, 2'b01, 50, 16'd14, 1'b0, 1'b0, 1'b0);
    run("rr_d", 2'b11, 2'b00, 2'b10, 2'b10, 50, 16'd333, 1'b0, 1'b0, 1'b0);

    // Divide by zero
    do_reset();
    i_num1 = 48'd500; i_den1 = 48'd0;
    run("dz", 2'b10, 2'b00, 2'b10, 2'b10, 2, 16'd0, 1'b1, 1'b0, 1'b0);

    // Saturation boundaries
    i_num0 = 48'h100_0000_0000; i_den0 = 48'd1;
    run("sat_big", 2'b01, 2'b00, 2'b01, 2'b01, 50, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    i_num0 = 48'd65535; i_den0 = 48'd1;
    run("sat_max", 2'b01, 2'b00, 2'b01, 2'b01, 50, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    i_num0 = 48'd65536; i_den0 = 48'd1;
    run("sat_edge", 2'b01, 2'b00, 2'b01, 2'b01, 50, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    // Reset mid-RUN at iteration 20 aborts silently
    i_num0 = 48'd1000; i_den0 = 48'd8;
    i_req = 2'b01;
    seen = 0;
    do begin @(negedge clk); seen++; end while (o_gnt == 2'b00 && seen < 10);
    chk("abort_gnt", 64'(o_gnt), 64'd1);
    i_req = 2'b00;
    repeat (21) @(negedge clk);
    chk("abort_busy_pre", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quo", 64'(o_quo), 64'd0);
    chk("abort_dz", 64'(o_dz), 64'd0);
    chk("abort_ovf", 64'(o_ovf), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_gnt0", 64'(o_gnt), 64'd0);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_done != 2'b00) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    i_num0 = 48'd1000; i_den0 = 48'd8;
    run("after_abort", 2'b01, 2'b00, 2'b01, 2'b01, 50, 16'd125, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
